// File: rtl/card_dealer.sv
// card_dealer: turns the LFSR nibble stream into a four-card hand for the 24 game.
// Out-of-range nibbles are rejected and redrawn; after MAX_TRIES rejections on one
// card a deterministic fallback value is used instead.
// Optional feature macro: DEALER_NO_REPEAT_EN (reject duplicates within a hand).
module card_dealer #(
  parameter int unsigned MAX_CARD  = 13,
  parameter int unsigned MAX_TRIES = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_deal,
  input  logic [3:0] i_rand_in,
  input  logic       i_rand_valid,
  output logic       o_rand_req,
  output logic [3:0] o_card0,
  output logic [3:0] o_card1,
  output logic [3:0] o_card2,
  output logic [3:0] o_card3,
  output logic       o_busy,
  output logic       o_dealt,
  output logic [7:0] o_reject_cnt
);

  localparam int unsigned NUM_CARDS = 4;
  localparam int unsigned CARD_W    = 4;
  localparam int unsigned IDX_W     = 2;
  localparam int unsigned CNT_W     = 8;

  localparam logic [CARD_W-1:0] LP_MAX_CARD  = CARD_W'(MAX_CARD);
  localparam logic [CARD_W-1:0] LP_MAX_TRIES = CARD_W'(MAX_TRIES);
  localparam logic [CNT_W-1:0]  LP_CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [CARD_W-1:0]   r_tries;
  logic [CARD_W-1:0]   r_cards [NUM_CARDS];
  logic [CNT_W-1:0]    r_reject_cnt;
  logic                r_rand_req;
  logic                r_busy;
  logic                r_dealt;

  logic                w_in_range;
  logic                w_dup;
  logic                w_reject;
  logic [CARD_W-1:0]   w_tries_inc;
  logic                w_fallback;
  logic [CARD_W-1:0]   w_fb_val;
  logic                w_write;
  logic [CARD_W-1:0]   w_wval;

  // Legal card window: 1..MAX_CARD, 4-bit unsigned compare.
  assign w_in_range = (i_rand_in != 4'd0) && (i_rand_in <= LP_MAX_CARD);

`ifdef DEALER_NO_REPEAT_EN
  // Flag a sample matching any card already dealt in this hand.
  always_comb begin
    w_dup = 1'b0;
    for (int i = 0; i < NUM_CARDS; i++) begin
      if ((IDX_W'(i) < r_idx) && (r_cards[i] == i_rand_in)) begin
        w_dup = 1'b1;
      end
    end
  end
`else
  assign w_dup = 1'b0;
`endif

  assign w_reject    = !w_in_range || w_dup;
  assign w_tries_inc = r_tries + 4'd1;
  assign w_fallback  = w_reject && (w_tries_inc == LP_MAX_TRIES);
  // Fallback folds the high nibble back into range; zero (or a duplicate) maps to 1.
  assign w_fb_val    = (i_rand_in > LP_MAX_CARD) ? (i_rand_in - LP_MAX_CARD) : 4'd1;
  assign w_write     = !w_reject || w_fallback;
  assign w_wval      = w_reject ? w_fb_val : i_rand_in;

  // Dealer FSM, card registers, retry tracking and reject statistics.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_tries      <= '0;
      r_reject_cnt <= '0;
      r_rand_req   <= 1'b0;
      r_busy       <= 1'b0;
      r_dealt      <= 1'b0;
      for (int i = 0; i < NUM_CARDS; i++) begin
        r_cards[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_dealt <= 1'b0;
          if (i_deal) begin
            r_state    <= S_DRAW;
            r_idx      <= '0;
            r_tries    <= '0;
            r_rand_req <= 1'b1;
            r_busy     <= 1'b1;
            for (int i = 0; i < NUM_CARDS; i++) begin
              r_cards[i] <= '0;
            end
          end
        end
        S_DRAW: begin
          if (i_rand_valid) begin
            if (w_reject && (r_reject_cnt != LP_CNT_MAX)) begin
              r_reject_cnt <= r_reject_cnt + 8'd1;
            end
            if (w_write) begin
              r_cards[r_idx] <= w_wval;
              r_tries        <= '0;
              if (r_idx == IDX_W'(NUM_CARDS - 1)) begin
                r_state    <= S_DONE;
                r_rand_req <= 1'b0;
                r_dealt    <= 1'b1;
              end else begin
                r_idx <= r_idx + 2'd1;
              end
            end else begin
              r_tries <= w_tries_inc;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_dealt <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_rand_req <= 1'b0;
          r_busy     <= 1'b0;
          r_dealt    <= 1'b0;
        end
      endcase
    end
  end

  assign o_rand_req   = r_rand_req;
  assign o_busy       = r_busy;
  assign o_dealt      = r_dealt;
  assign o_reject_cnt = r_reject_cnt;
  assign o_card0      = r_cards[0];
  assign o_card1      = r_cards[1];
  assign o_card2      = r_cards[2];
  assign o_card3      = r_cards[3];

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: default instance plus a MAX_TRIES=2 instance.
module tb_card_dealer;

  logic       clk;
  logic       rst;
  logic       deal, rand_valid;
  logic [3:0] rand_in;
  logic       rand_req, busy, dealt;
  logic [3:0] card0, card1, card2, card3;
  logic [7:0] reject_cnt;

  logic       fb_deal, fb_rand_valid;
  logic [3:0] fb_rand_in;
  logic       fb_rand_req, fb_busy, fb_dealt;
  logic [3:0] fb_card0, fb_card1, fb_card2, fb_card3;
  logic [7:0] fb_reject_cnt;

  int checks = 0;
  int errors = 0;

  card_dealer dut (
    .i_clk(clk), .i_rst(rst), .i_deal(deal), .i_rand_in(rand_in),
    .i_rand_valid(rand_valid), .o_rand_req(rand_req),
    .o_card0(card0), .o_card1(card1), .o_card2(card2), .o_card3(card3),
    .o_busy(busy), .o_dealt(dealt), .o_reject_cnt(reject_cnt)
  );

  card_dealer #(.MAX_CARD(13), .MAX_TRIES(2)) dut_fb (
    .i_clk(clk), .i_rst(rst), .i_deal(fb_deal), .i_rand_in(fb_rand_in),
    .i_rand_valid(fb_rand_valid), .o_rand_req(fb_rand_req),
    .o_card0(fb_card0), .o_card1(fb_card1), .o_card2(fb_card2), .o_card3(fb_card3),
    .o_busy(fb_busy), .o_dealt(fb_dealt), .o_reject_cnt(fb_reject_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_cards(input string tag, input logic [3:0] e0, input logic [3:0] e1,
                           input logic [3:0] e2, input logic [3:0] e3);
    chk({tag, "_card0"}, 32'(card0), 32'(e0));
    chk({tag, "_card1"}, 32'(card1), 32'(e1));
    chk({tag, "_card2"}, 32'(card2), 32'(e2));
    chk({tag, "_card3"}, 32'(card3), 32'(e3));
  endtask

  // Start a deal at a negedge and feed seq[0..n-1] (last value repeats) until dealt.
  task automatic run_deal(input string tag, input logic [3:0] seq [0:7], input int n,
                          input int exp_lat);
    int j;
    int lat;
    j = 0;
    deal = 1'b1; rand_valid = 1'b1; rand_in = seq[0];
    @(negedge clk);
    deal = 1'b0;
    lat = 1;
    chk({tag, "_busy_start"}, 32'(busy), 32'd1);
    chk({tag, "_req_start"}, 32'(rand_req), 32'd1);
    while (!dealt && lat < 200) begin
      rand_in = seq[(j < n) ? j : n - 1];
      j++;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_dealt"}, 32'(dealt), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy_done"}, 32'(busy), 32'd1);
    chk({tag, "_req_done"}, 32'(rand_req), 32'd0);
    @(negedge clk);
    chk({tag, "_dealt_pulse"}, 32'(dealt), 32'd0);
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  // Fallback instance: hold one value for the whole deal.
  task automatic run_fb(input string tag, input logic [3:0] v, input int exp_lat);
    int lat;
    fb_deal = 1'b1; fb_rand_valid = 1'b1; fb_rand_in = v;
    @(negedge clk);
    fb_deal = 1'b0;
    lat = 1;
    while (!fb_dealt && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_dealt"}, 32'(fb_dealt), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    @(negedge clk);
    chk({tag, "_busy_idle"}, 32'(fb_busy), 32'd0);
  endtask

  initial begin
    logic [3:0] seq [0:7];
    int dealt_at [0:3];
    int nd;

    rst = 1'b0; deal = 1'b0; rand_valid = 1'b0; rand_in = 4'd0;
    fb_deal = 1'b0; fb_rand_valid = 1'b0; fb_rand_in = 4'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset state
    chk_cards("reset", 4'd0, 4'd0, 4'd0, 4'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_req", 32'(rand_req), 32'd0);
    chk("reset_dealt", 32'(dealt), 32'd0);
    chk("reset_rejects", 32'(reject_cnt), 32'd0);
    chk("reset_fb_rejects", 32'(fb_reject_cnt), 32'd0);

    // Basic deal: 3,7,12,1
    seq = '{4'd3, 4'd7, 4'd12, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
    run_deal("basic", seq, 4, 5);
    chk_cards("basic", 4'd3, 4'd7, 4'd12, 4'd1);
    chk("basic_rejects", 32'(reject_cnt), 32'd0);
    // rand_valid high in IDLE with a junk nibble must not touch the hand
    rand_in = 4'd9;
    @(negedge clk);
    @(negedge clk);
    chk_cards("idle_hold", 4'd3, 4'd7, 4'd12, 4'd1);
    chk("idle_hold_rejects", 32'(reject_cnt), 32'd0);

    // Rejects: 0,15,5,14,9,2,13
    seq = '{4'd0, 4'd15, 4'd5, 4'd14, 4'd9, 4'd2, 4'd13, 4'd13};
    run_deal("rejects", seq, 7, 8);
    chk_cards("rejects", 4'd5, 4'd9, 4'd2, 4'd13);
    chk("rejects_cnt", 32'(reject_cnt), 32'd3);

    // Fallback on MAX_TRIES=2 instance: 15 -> 2, 0 -> 1
    run_fb("fb15", 4'd15, 9);
    chk("fb15_card0", 32'(fb_card0), 32'd2);
    chk("fb15_card1", 32'(fb_card1), 32'd2);
    chk("fb15_card2", 32'(fb_card2), 32'd2);
    chk("fb15_card3", 32'(fb_card3), 32'd2);
    chk("fb15_rejects", 32'(fb_reject_cnt), 32'd8);
    run_fb("fb0", 4'd0, 9);
    chk("fb0_card0", 32'(fb_card0), 32'd1);
    chk("fb0_card3", 32'(fb_card3), 32'd1);
    chk("fb0_rejects", 32'(fb_reject_cnt), 32'd16);

    // Duplicate handling: 4,4,6,6,4,8,10
    seq = '{4'd4, 4'd4, 4'd6, 4'd6, 4'd4, 4'd8, 4'd10, 4'd10};
`ifdef DEALER_NO_REPEAT_EN
    run_deal("norepeat", seq, 7, 8);
    chk_cards("norepeat", 4'd4, 4'd6, 4'd8, 4'd10);
    chk("norepeat_rejects", 32'(reject_cnt), 32'd6);
`else
    run_deal("repeat", seq, 7, 5);
    chk_cards("repeat", 4'd4, 4'd4, 4'd6, 4'd6);
    chk("repeat_rejects", 32'(reject_cnt), 32'd3);
`endif

    // Back-to-back with deal held high; nibble cycles 1..4 per cycle
    nd = 0;
    deal = 1'b1; rand_valid = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      rand_in = 4'((c % 4) + 1);
      @(negedge clk);
      if (dealt && nd < 4) begin
        dealt_at[nd] = c;
        nd++;
      end
    end
    deal = 1'b0;
    chk("b2b_count", 32'(nd), 32'd3);
    chk("b2b_first", 32'(dealt_at[0]), 32'd4);
    chk("b2b_gap1", 32'(dealt_at[1] - dealt_at[0]), 32'd6);
    chk("b2b_gap2", 32'(dealt_at[2] - dealt_at[1]), 32'd6);
    chk_cards("b2b", 4'd2, 4'd3, 4'd4, 4'd1);
    @(negedge clk);
    chk("b2b_busy_idle", 32'(busy), 32'd0);
`ifdef DEALER_NO_REPEAT_EN
    chk("b2b_rejects", 32'(reject_cnt), 32'd6);
`else
    chk("b2b_rejects", 32'(reject_cnt), 32'd3);
`endif

    // Stall mid-deal (deal also asserted, must be ignored), then reset
    deal = 1'b1; rand_valid = 1'b1; rand_in = 4'd5;
    @(negedge clk);
    deal = 1'b0; rand_in = 4'd5;
    @(negedge clk);
    rand_in = 4'd6;
    @(negedge clk);
    rand_valid = 1'b0; rand_in = 4'd7; deal = 1'b1;
    repeat (4) @(negedge clk);
    chk_cards("stall", 4'd5, 4'd6, 4'd0, 4'd0);
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_req", 32'(rand_req), 32'd1);
    chk("stall_dealt", 32'(dealt), 32'd0);
    rst = 1'b0; deal = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk_cards("midreset", 4'd0, 4'd0, 4'd0, 4'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_req", 32'(rand_req), 32'd0);
    chk("midreset_rejects", 32'(reject_cnt), 32'd0);
    rand_valid = 1'b1;
    @(negedge clk);
    chk("midreset_dealt", 32'(dealt), 32'd0);
    chk("midreset_stays_idle", 32'(busy), 32'd0);
    seq = '{4'd1, 4'd2, 4'd3, 4'd13, 4'd0, 4'd0, 4'd0, 4'd0};
    run_deal("afterreset", seq, 4, 5);
    chk_cards("afterreset", 4'd1, 4'd2, 4'd3, 4'd13);
    chk("afterreset_rejects", 32'(reject_cnt), 32'd0);

    // Saturation: 10 deals of 32 rejects each (0 held, fallback gives 1)
    seq = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    for (int d = 1; d <= 10; d++) begin
      run_deal("sat", seq, 1, 33);
      if (d == 7) chk("sat_224", 32'(reject_cnt), 32'd224);
      if (d == 8) chk("sat_255", 32'(reject_cnt), 32'd255);
    end
    chk("sat_hold", 32'(reject_cnt), 32'd255);
    chk_cards("sat", 4'd1, 4'd1, 4'd1, 4'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
